// File: rtl/goal_seek_pkg.sv
// goal_seek_pkg: shared types and constants for the goal-seek direction controller.
//   state_e       - controller states
//   STOP..REVERSE - H-bridge direction words, bit order {fwd_a, fwd_b, bwd_a, bwd_b}
//   DUTY_OFF      - duty code driven while the motors are stopped
//   cyc_w()       - timer width needed to hold the largest (cycle count - 1)
package goal_seek_pkg;

  typedef enum logic [2:0] {IDLE, SEARCH, NUDGE, BACKOFF, PAUSE, FAULT} state_e;

  localparam logic [3:0] STOP    = 4'b0000;
  localparam logic [3:0] SPIN_R  = 4'b1001;
  localparam logic [3:0] SPIN_L  = 4'b0110;
  localparam logic [3:0] REVERSE = 4'b0011;

  localparam int unsigned DUTY_OFF = 0;

  // The timer only ever holds (count - 1), so clog2 of the largest count suffices.
  function automatic int unsigned cyc_w(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/goal_seek_timer.sv
// goal_seek_timer: loadable, freezable down-counter shared by the nudge,
// backoff and search phases.
//   load/load_val - load a new count (loading 0 clears it)
//   run           - decrement by one; while low the count is frozen
//   expired       - count has reached zero (last clock of the phase)
module goal_seek_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         expired
);
  import goal_seek_pkg::*;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (run && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/goal_seek_ctrl.sv
// goal_seek_ctrl: spin-search for IR goal beacons, nudge toward a hit, back off
// from the boundary wire, with pause/freeze and a search timeout fault.
//   enable (rising edge) starts a search; pause freezes motors and timer;
//   inductance forces a backoff; ir_hit[NUM_CH] picks the nudge channel.
//   Outputs: H-bridge lines fwd_a/fwd_b/bwd_a/bwd_b, duty selects, done, busy,
//   sticky fault, and hit_ch (last channel that caused a nudge).
//   All outputs are registered and decoded from the next state.
module goal_seek_ctrl
  import goal_seek_pkg::*;
#(
  parameter int unsigned          CLK_HZ      = 100_000_000,
  parameter int                   NUM_CH      = 2,
  parameter logic [NUM_CH-1:0]    CH_DIR      = 2'b01,
  parameter int                   DUTY_W      = 2,
  parameter int unsigned          NUDGE_CYC   = 100_000_000,
  parameter int unsigned          BACKOFF_CYC = 200_000_000,
  parameter int unsigned          SEARCH_CYC  = 1_500_000_000,
  parameter int unsigned          DUTY_SEARCH = 1,
  parameter int unsigned          DUTY_NUDGE  = 2,
  parameter int unsigned          DUTY_BACK   = 3,
  localparam int                  HW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              pause,
  input  logic              inductance,
  input  logic [NUM_CH-1:0] ir_hit,
  input  logic              search_dir,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic              bwd_a,
  output logic              bwd_b,
  output logic [DUTY_W-1:0] duty_sel_a,
  output logic [DUTY_W-1:0] duty_sel_b,
  output logic              done,
  output logic              busy,
  output logic              fault,
  output logic [HW-1:0]     hit_ch
);

  localparam int TW = cyc_w(NUDGE_CYC, BACKOFF_CYC, SEARCH_CYC);
  localparam logic [TW-1:0] LD_N = TW'((NUDGE_CYC   == 0) ? 0 : NUDGE_CYC   - 1);
  localparam logic [TW-1:0] LD_B = TW'((BACKOFF_CYC == 0) ? 0 : BACKOFF_CYC - 1);
  localparam logic [TW-1:0] LD_S = TW'((SEARCH_CYC  == 0) ? 0 : SEARCH_CYC  - 1);

  if (NUM_CH < 1 || NUM_CH > 8 || CLK_HZ == 0) begin : g_param_err
    $error("goal_seek_ctrl: NUM_CH must be 1..8 and CLK_HZ nonzero");
  end

  state_e          st, nxt, saved;
  logic            en_q, en_seen, rise;
  logic            dir_l, dir_nxt;        // latched search direction, 1 = left
  logic [HW-1:0]   hit_nxt, low_idx;
  logic            expired, tload, trun;
  logic [TW-1:0]   tval;
  logic [3:0]      mot;

  // en_seen keeps the first sample after reset from counting as a rising
  // edge, so enable held high through reset release does not start a run.
  assign rise = en_seen & ~en_q & enable;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (ir_hit[i]) low_idx = HW'(i);
  end

  always_comb begin
    nxt     = st;
    dir_nxt = dir_l;
    hit_nxt = hit_ch;
    case (st)
      IDLE, FAULT: if (rise) begin nxt = SEARCH; dir_nxt = search_dir; end
      PAUSE:       if (!pause) nxt = saved;
      SEARCH: begin
        if (pause)            nxt = PAUSE;
        else if (inductance)  nxt = BACKOFF;
        else if (|ir_hit) begin nxt = NUDGE; hit_nxt = low_idx; end
        else if (SEARCH_CYC != 0 && expired) nxt = FAULT;
      end
      NUDGE: begin
        if (pause)            nxt = PAUSE;
        else if (inductance)  nxt = BACKOFF;
        else if (expired)     nxt = IDLE;
      end
      BACKOFF: begin
        if (pause)            nxt = PAUSE;
        else if (expired)     nxt = inductance ? BACKOFF : SEARCH;
      end
      default:                nxt = IDLE;
    endcase
  end

  // Timer reloads on every state entry (including a backoff restart) but
  // neither on entry to PAUSE nor on the return from it, so the count freezes.
  always_comb begin
    tload = ((nxt != st) && (st != PAUSE) && (nxt != PAUSE)) ||
            ((st == BACKOFF) && (nxt == BACKOFF) && expired);
    trun  = (nxt == st) && (st == SEARCH || st == NUDGE || st == BACKOFF);
    case (nxt)
      SEARCH:  tval = LD_S;
      NUDGE:   tval = LD_N;
      BACKOFF: tval = LD_B;
      default: tval = '0;
    endcase
  end

  goal_seek_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tload),
    .load_val (tval),
    .run      (trun),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      saved      <= IDLE;
      en_q       <= 1'b0;
      en_seen    <= 1'b0;
      dir_l      <= 1'b0;
      hit_ch     <= '0;
      mot        <= STOP;
      duty_sel_a <= '0;
      duty_sel_b <= '0;
      done       <= 1'b1;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      st      <= nxt;
      en_q    <= enable;
      en_seen <= 1'b1;
      dir_l   <= dir_nxt;
      hit_ch  <= hit_nxt;
      if (nxt == PAUSE && st != PAUSE) saved <= st;
      done    <= (nxt == IDLE);
      busy    <= (nxt != IDLE) && (nxt != FAULT);
      fault   <= (nxt == FAULT);
      case (nxt)
        SEARCH: begin
          mot        <= dir_nxt ? SPIN_L : SPIN_R;
          duty_sel_a <= DUTY_W'(DUTY_SEARCH);
          duty_sel_b <= DUTY_W'(DUTY_SEARCH);
        end
        NUDGE: begin
          mot        <= CH_DIR[hit_nxt] ? SPIN_R : SPIN_L;
          duty_sel_a <= DUTY_W'(DUTY_NUDGE);
          duty_sel_b <= DUTY_W'(DUTY_NUDGE);
        end
        BACKOFF: begin
          mot        <= REVERSE;
          duty_sel_a <= DUTY_W'(DUTY_BACK);
          duty_sel_b <= DUTY_W'(DUTY_BACK);
        end
        default: begin
          mot        <= STOP;
          duty_sel_a <= DUTY_W'(DUTY_OFF);
          duty_sel_b <= DUTY_W'(DUTY_OFF);
        end
      endcase
    end
  end

  assign {fwd_a, fwd_b, bwd_a, bwd_b} = mot;

endmodule
